// File: rtl/bcd_prescaled_counter.sv
// bcd_prescaled_counter: multi-digit BCD up/down counter stepped by an
// internal clock prescaler, with enable, synchronous load (per-digit clamp)
// and a one-cycle wrap indication.
// Optional build macro: BCD_SATURATE_EN -- stop at all-9s / all-0s instead
// of wrapping; carry then flags each step that was blocked at the limit.
module bcd_prescaled_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  carry
);

    localparam int unsigned CW = 4 * DIGITS;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;
    logic          carry_q, carry_d;

    logic [CW-1:0] stepped;
    logic          ripple;
    logic [3:0]    dig;
    logic          presc_last;

    // Clamp every digit of a load value into 0..9.
    function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    assign presc_last = (presc_q == PRESC_LAST);

    // Ripple +1 / -1 through all digits; ripple left set means the whole counter wrapped.
    always_comb begin
        stepped = count_q;
        ripple  = 1'b1;
        dig     = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig = count_q[4*i +: 4];
            if (ripple) begin
                if (up) begin
                    if (dig >= 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = dig + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = dig - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
    end

    // Next-state: load beats a coincident step; en gates prescaler and steps.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        if (load) begin
            count_d = clamp_bcd(load_val);
            presc_d = '0;
        end else if (en) begin
            presc_d = presc_last ? '0 : presc_q + PW'(1);
            if (presc_last) begin
                tick_d  = 1'b1;
                carry_d = ripple;
`ifdef BCD_SATURATE_EN
                count_d = ripple ? count_q : stepped;
`else
                count_d = stepped;
`endif
            end
        end
    end

    // State registers with asynchronous active-high clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_bcd_prescaled_counter.sv
// Bench for bcd_prescaled_counter: DIGITS=2/PRESCALE=11 instance driven by a
// vector table, plus a DIGITS=2/PRESCALE=1 instance for the every-cycle case.
// Expectations follow BCD_SATURATE_EN when it is defined.
module tb_bcd_prescaled_counter;

`ifdef BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up, load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tick, carry;

    logic       en_b, up_b, load_b;
    logic [7:0] load_val_b;
    logic [7:0] count_b;
    logic       tick_b, carry_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_prescaled_counter #(.DIGITS(2), .PRESCALE(11)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tick(tick), .carry(carry)
    );

    bcd_prescaled_counter #(.DIGITS(2), .PRESCALE(1)) dut_p1 (
        .clk(clk), .reset(reset), .en(en_b), .up(up_b), .load(load_b),
        .load_val(load_val_b), .count(count_b), .tick(tick_b), .carry(carry_b)
    );

    typedef struct {
        string      name;
        bit         ld;
        logic [7:0] lv;
        bit         en;
        bit         up;
        int         edges;
        logic [7:0] exp_count;
        bit         exp_tick;
        bit         exp_carry;
        int         exp_ticks;
        int         exp_carries;
        int         exp_first;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Clock n edges, sampling 1 time unit after each; tally tick/carry pulses.
    task automatic run(input int n, output int ticks, output int carries, output int first);
        ticks = 0; carries = 0; first = 0;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            if (tick === 1'b1) begin
                ticks++;
                if (first == 0) first = e;
            end
            if (carry === 1'b1) carries++;
        end
    endtask

    initial begin
        int tk, cy, fs;

        //             name        ld lv     en up edges cnt    tk cy ticks carries first
        vq.push_back('{"up110",    0, 8'h00, 1, 1, 110, 8'h10, 1, 0, 10, 0, 11});
        vq.push_back('{"ld99",     1, 8'h99, 1, 1, 1,   8'h99, 0, 0, 0,  0, 0});
        vq.push_back('{"upwrap",   0, 8'h00, 1, 1, 11,  SAT ? 8'h99 : 8'h00, 1, 1, 1, 1, 11});
        vq.push_back('{"wraphold", 0, 8'h00, 1, 1, 1,   SAT ? 8'h99 : 8'h00, 0, 0, 0, 0, 0});
        vq.push_back('{"ld10",     1, 8'h10, 1, 0, 1,   8'h10, 0, 0, 0,  0, 0});
        vq.push_back('{"dn09",     0, 8'h00, 1, 0, 11,  8'h09, 1, 0, 1,  0, 11});
        vq.push_back('{"dn08",     0, 8'h00, 1, 0, 11,  8'h08, 1, 0, 1,  0, 11});
        vq.push_back('{"ld00",     1, 8'h00, 1, 0, 1,   8'h00, 0, 0, 0,  0, 0});
        vq.push_back('{"dnwrap",   0, 8'h00, 1, 0, 11,  SAT ? 8'h00 : 8'h99, 1, 1, 1, 1, 11});
        vq.push_back('{"ld00b",    1, 8'h00, 1, 1, 1,   8'h00, 0, 0, 0,  0, 0});
        vq.push_back('{"pre10",    0, 8'h00, 1, 1, 10,  8'h00, 0, 0, 0,  0, 0});
        vq.push_back('{"ldstep",   1, 8'hAF, 1, 1, 1,   8'h99, 0, 0, 0,  0, 0});
        vq.push_back('{"post10",   0, 8'h00, 1, 1, 10,  8'h99, 0, 0, 0,  0, 0});
        vq.push_back('{"post11",   0, 8'h00, 1, 1, 1,   SAT ? 8'h99 : 8'h00, 1, 1, 1, 1, 1});
        vq.push_back('{"ldC4",     1, 8'hC4, 1, 1, 1,   8'h94, 0, 0, 0,  0, 0});
        vq.push_back('{"run5",     0, 8'h00, 1, 1, 5,   8'h94, 0, 0, 0,  0, 0});
        vq.push_back('{"freeze",   0, 8'h00, 0, 1, 20,  8'h94, 0, 0, 0,  0, 0});
        vq.push_back('{"resume",   0, 8'h00, 1, 1, 6,   8'h95, 1, 0, 1,  0, 6});
        vq.push_back('{"updn5",    0, 8'h00, 1, 0, 5,   8'h95, 0, 0, 0,  0, 0});
        vq.push_back('{"upback",   0, 8'h00, 1, 1, 6,   8'h96, 1, 0, 1,  0, 6});
        vq.push_back('{"ldnoen",   1, 8'h42, 0, 0, 1,   8'h42, 0, 0, 0,  0, 0});

        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; load_val_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_carry", 32'(carry), 32'h0);
        #4 reset = 1'b0;

        // Asynchronous reset in the middle of a prescale period at 0x37.
        load = 1'b1; load_val = 8'h37;
        run(1, tk, cy, fs);
        load = 1'b0; en = 1'b1; up = 1'b1;
        run(5, tk, cy, fs);
        chk("pre_rst_count", 32'(count), 32'h37);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'h0);
        chk("async_rst_tick", 32'(tick), 32'h0);
        chk("async_rst_carry", 32'(carry), 32'h0);
        #1 reset = 1'b0;

        foreach (vq[i]) begin
            load = vq[i].ld; load_val = vq[i].lv; en = vq[i].en; up = vq[i].up;
            run(vq[i].edges, tk, cy, fs);
            chk({vq[i].name, "_count"}, 32'(count), 32'(vq[i].exp_count));
            chk({vq[i].name, "_tick"}, 32'(tick), 32'(vq[i].exp_tick));
            chk({vq[i].name, "_carry"}, 32'(carry), 32'(vq[i].exp_carry));
            chk({vq[i].name, "_nticks"}, 32'(tk), 32'(vq[i].exp_ticks));
            chk({vq[i].name, "_ncarry"}, 32'(cy), 32'(vq[i].exp_carries));
            chk({vq[i].name, "_first"}, 32'(fs), 32'(vq[i].exp_first));
        end
        load = 1'b0; en = 1'b0;

        // PRESCALE=1: a step on every enabled edge.
        chk("p1_idle_count", 32'(count_b), 32'h0);
        en_b = 1'b1; up_b = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("p1_count_%0d", e), 32'(count_b), 32'(e));
            chk($sformatf("p1_tick_%0d", e), 32'(tick_b), 32'h1);
            chk($sformatf("p1_carry_%0d", e), 32'(carry_b), 32'h0);
        end
        en_b = 1'b0;
        @(posedge clk);
        #1;
        chk("p1_stop_tick", 32'(tick_b), 32'h0);
        chk("p1_stop_count", 32'(count_b), 32'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
